// File: rtl/flippy_pkg.sv
// Shared definitions for the FlippyBit game: phase encoding and the saturating
// hit accumulator used by the sequencer and lane scorers.
package flippy_pkg;

    localparam int unsigned MAX_LANES = 16;

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_POINT     = 3'd2,
        ST_MISS      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    // value + popcount(add), clamped to 2^width-1; width must be below 32
    function automatic logic [31:0] popcount_sat(input logic [31:0]          value,
                                                 input logic [MAX_LANES-1:0] add,
                                                 input int unsigned          width);
        logic [32:0] sum;
        logic [32:0] limit;
        sum = {1'b0, value};
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            sum = sum + 33'(add[i]);
        end
        limit = (33'd1 << width) - 33'd1;
        return (sum > limit) ? limit[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/flippy_score_accum.sv
// Saturating score register with best-score tracking and a one-cycle
// new-best pulse, driven by clear/add/commit strobes from the sequencer.
module flippy_score_accum
    import flippy_pkg::*;
#(
    parameter int unsigned LANES   = 3,
    parameter int unsigned SCORE_W = 8
) (
    input  logic               clock,
    input  logic               reset_button_n,
    input  logic               clear_i,
    input  logic               add_i,
    input  logic [LANES-1:0]   hits_i,
    input  logic               commit_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] best_score_o,
    output logic               new_best_o
);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               new_best_q, new_best_d;

    always_ff @(posedge clock or negedge reset_button_n) begin
        if (!reset_button_n) begin
            score_q    <= '0;
            best_q     <= '0;
            new_best_q <= 1'b0;
        end else begin
            score_q    <= score_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    always_comb begin
        score_d    = score_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        if (clear_i) begin
            score_d = '0;
        end else if (add_i) begin
            score_d = SCORE_W'(popcount_sat(32'(score_q), MAX_LANES'(hits_i), SCORE_W));
        end
        // Only a strictly higher score replaces the record
        if (commit_i && (score_q > best_q)) begin
            best_d     = score_q;
            new_best_d = 1'b1;
        end
    end

    assign score_o      = score_q;
    assign best_score_o = best_q;
    assign new_best_o   = new_best_q;

endmodule

// File: rtl/flippy_game_sequencer.sv
// FlippyBit top-level controller: sequences clear, run, point, miss and
// game-over phases and owns lives, lane-clear strobe and start-edge detect.
module flippy_game_sequencer
    import flippy_pkg::*;
#(
    parameter int unsigned LANES        = 3,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset_button_n,
    input  logic               start_button,
    input  logic [LANES-1:0]   game_over,
    input  logic [LANES-1:0]   correct,
    output logic               reset_signal,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score,
    output logic [3:0]         lives_left,
    output logic               new_best,
    output logic [2:0]         state_out
);

    localparam int unsigned     CNT_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [3:0]      LIVES_INIT = 4'(LIVES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [3:0]       lives_q, lives_d;
    logic [LANES-1:0] hits_q, hits_d;
    logic             start_q;
    logic             reset_sig_q, reset_sig_d;
    logic             acc_clear, acc_add, acc_commit;
    logic             any_miss, any_hit, start_rise;

    assign any_miss   = |game_over;
    assign any_hit    = |correct;
    assign start_rise = start_button & ~start_q;

    always_ff @(posedge clock or negedge reset_button_n) begin
        if (!reset_button_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            lives_q     <= LIVES_INIT;
            hits_q      <= '0;
            start_q     <= 1'b0;
            reset_sig_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            lives_q     <= lives_d;
            hits_q      <= hits_d;
            start_q     <= start_button;
            reset_sig_q <= reset_sig_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = '0;
        lives_d    = lives_q;
        hits_d     = hits_q;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        acc_commit = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                lives_d = LIVES_INIT;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUNNING;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            ST_RUNNING: begin
                // A miss wins over a simultaneous hit; the hit is dropped
                if (any_miss) begin
                    state_d = ST_MISS;
                    lives_d = lives_q - 4'd1;
                end else if (any_hit) begin
                    state_d = ST_POINT;
                    hits_d  = correct;
                end
            end
            ST_POINT: begin
                acc_add = 1'b1;
                state_d = ST_RUNNING;
            end
            ST_MISS: begin
                if (lives_q == 4'd0) begin
                    state_d    = ST_GAME_OVER;
                    acc_commit = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d   = ST_CLEAR;
                    acc_clear = 1'b1;
                    lives_d   = LIVES_INIT;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                acc_clear = 1'b1;
                lives_d   = LIVES_INIT;
            end
        endcase
        reset_sig_d = (state_d == ST_CLEAR) || (state_d == ST_MISS);
    end

    flippy_score_accum #(
        .LANES   (LANES),
        .SCORE_W (SCORE_W)
    ) u_score (
        .clock          (clock),
        .reset_button_n (reset_button_n),
        .clear_i        (acc_clear),
        .add_i          (acc_add),
        .hits_i         (hits_q),
        .commit_i       (acc_commit),
        .score_o        (score),
        .best_score_o   (best_score),
        .new_best_o     (new_best)
    );

    assign reset_signal = reset_sig_q;
    assign lives_left   = lives_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_flippy_game_sequencer.sv
// Scoreboarded random/directed bench for flippy_game_sequencer against a
// phase-level game model.
module tb_flippy_game_sequencer;

    localparam int LANES  = 3;
    localparam int SW     = 4;
    localparam int LIVES  = 3;
    localparam int CLRCYC = 4;
    localparam int MAXS   = (1 << SW) - 1;

    localparam int P_CLEAR = 0, P_RUN = 1, P_POINT = 2, P_MISS = 3, P_OVER = 4;

    logic             clock = 1'b0;
    logic             reset_button_n;
    logic             start_button;
    logic [LANES-1:0] game_over;
    logic [LANES-1:0] correct;
    logic             reset_signal;
    logic [SW-1:0]    score;
    logic [SW-1:0]    best_score;
    logic [3:0]       lives_left;
    logic             new_best;
    logic [2:0]       state_out;

    flippy_game_sequencer #(
        .LANES(LANES), .SCORE_W(SW), .LIVES(LIVES), .CLEAR_CYCLES(CLRCYC)
    ) dut (
        .clock          (clock),
        .reset_button_n (reset_button_n),
        .start_button   (start_button),
        .game_over      (game_over),
        .correct        (correct),
        .reset_signal   (reset_signal),
        .score          (score),
        .best_score     (best_score),
        .lives_left     (lives_left),
        .new_best       (new_best),
        .state_out      (state_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int phase;
        int score;
        int best;
        int lives;
        int newbest;
        int rsig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    // Game model state
    int m_phase, m_clr, m_score, m_best, m_lives, m_newbest, m_pend, m_start_prev, m_rsig;

    task automatic model_step(input bit r, input bit s, input int g, input int c);
        if (!r) begin
            m_phase = P_CLEAR; m_clr = 0; m_score = 0; m_best = 0;
            m_lives = LIVES; m_newbest = 0; m_start_prev = 0; m_rsig = 1;
            return;
        end
        m_newbest = 0;
        case (m_phase)
            P_CLEAR: begin
                m_clr++;
                if (m_clr == CLRCYC) begin m_phase = P_RUN; m_clr = 0; end
            end
            P_RUN: begin
                if (g != 0) begin
                    m_lives--; m_phase = P_MISS;
                end else if (c != 0) begin
                    m_pend = $countones(c); m_phase = P_POINT;
                end
            end
            P_POINT: begin
                m_score = (m_score + m_pend > MAXS) ? MAXS : m_score + m_pend;
                m_phase = P_RUN;
            end
            P_MISS: begin
                if (m_lives == 0) begin
                    m_phase = P_OVER;
                    if (m_score > m_best) begin m_best = m_score; m_newbest = 1; end
                end else m_phase = P_RUN;
            end
            default: begin
                if (s && !m_start_prev) begin
                    m_phase = P_CLEAR; m_score = 0; m_lives = LIVES; m_clr = 0;
                end
            end
        endcase
        m_start_prev = int'(s);
        m_rsig = (m_phase == P_CLEAR || m_phase == P_MISS) ? 1 : 0;
    endtask

    task automatic cyc(input bit r, input bit s, input int g, input int c);
        exp_t e;
        @(negedge clock);
        reset_button_n = r;
        start_button   = s;
        game_over      = LANES'(g);
        correct        = LANES'(c);
        model_step(r, s, g, c);
        e.phase = m_phase; e.score = m_score; e.best = m_best;
        e.lives = m_lives; e.newbest = m_newbest; e.rsig = m_rsig;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, ncyc, got, want);
        end
    endtask

    // Monitor: one expectation is consumed per clock once stimulus is flowing
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            ncyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state_out",    int'(state_out),    e.phase);
                chk("score",        int'(score),        e.score);
                chk("best_score",   int'(best_score),   e.best);
                chk("lives_left",   int'(lives_left),   e.lives);
                chk("new_best",     int'(new_best),     e.newbest);
                chk("reset_signal", int'(reset_signal), e.rsig);
            end
        end
    end

    initial begin
        reset_button_n = 1'b0;
        start_button   = 1'b0;
        game_over      = '0;
        correct        = '0;

        // Reset, then the clear phase runs out into RUNNING
        repeat (2) cyc(0, 0, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);

        // Two-lane hit, then miss beating a simultaneous hit
        cyc(1, 0, 0, 3'b000);
        cyc(1, 0, 0, 3'b101);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 3'b001, 3'b010);
        repeat (2) cyc(1, 0, 0, 0);

        // Climb into saturation
        repeat (7) begin
            cyc(1, 0, 0, 3'b111);
            cyc(1, 0, 0, 0);
        end

        // Finish the game with start held high across game-over entry
        cyc(1, 0, 3'b100, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 3'b010, 3'b111);
        repeat (4) cyc(1, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);

        // Second game ties the record: no new-best pulse
        repeat (6) begin
            cyc(1, 0, 0, 3'b111);
            cyc(1, 0, 0, 0);
        end
        repeat (3) begin
            cyc(1, 0, 3'b111, 0);
            cyc(1, 0, 0, 0);
        end
        repeat (2) cyc(1, 0, 0, 0);

        // Restart, score a little, then abort with reset mid-run
        cyc(1, 1, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 3'b011);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 3'b001);
        cyc(0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0);

        // Randomised play
        repeat (3000) begin
            int g, c;
            bit s, r;
            g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
            c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : 0;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 599) != 0);
            cyc(r, s, g, c);
        end

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
